// File: rtl/branch_resolve_unit_pkg.sv
// Purpose: shared types for the branch resolve unit (verdict, FSM state, queue entry).
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package datapath_types_pkg;

  // Verdict handed to the predictor for its update.
  typedef enum logic [1:0] {
    NO_PRED    = 2'd0,
    RIGHT_PRED = 2'd1,
    WRONG_PRED = 2'd2
  } pred_t;

  // Resolve-unit control state: RECOVER lasts exactly one cycle after a mispredict.
  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } bru_state_t;

  // One in-flight prediction, captured at decode and checked at mem.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bru_entry_t;

  // Sequential fetch address after a branch that resolved not-taken.
  function automatic logic [31:0] bru_fallthrough(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Purpose: pipeline-side bundle of the branch resolve unit (decode push, mem resolve, verdict).
// Latency: wires only.
// Backpressure: full tells decode to stall; stall freezes both push and pop.
interface branch_resolve_unit_if;
  import datapath_types_pkg::*;

  // decode stage: prediction being recorded
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic        dec_taken;
  logic [31:0] dec_target;

  // pipeline freeze
  logic        stall;

  // mem stage: actual outcome
  logic        mem_valid;
  logic        mem_taken;
  logic [31:0] mem_target;

  // verdict and recovery
  pred_t       pred_result;
  logic [31:0] pc_mem;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        full;
  logic        err;

  // pipeline side
  modport master (
    output dec_valid, dec_pc, dec_taken, dec_target,
    output stall,
    output mem_valid, mem_taken, mem_target,
    input  pred_result, pc_mem, flush, redirect_pc, full, err
  );

  // resolve-unit side
  modport slave (
    input  dec_valid, dec_pc, dec_taken, dec_target,
    input  stall,
    input  mem_valid, mem_taken, mem_target,
    output pred_result, pc_mem, flush, redirect_pc, full, err
  );

endinterface

// File: rtl/branch_resolve_unit_fifo.sv
// Purpose: circular queue of in-flight predictions with a single-edge clear.
// Latency: push visible at head one cycle later; head data is read combinationally.
// Backpressure: caller must not push when full unless popping in the same cycle.
module bru_fifo
  import datapath_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  bru_entry_t push_dat,
  output bru_entry_t head_dat,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW:0]   count;
  bru_entry_t    mem [DEPTH];

  // pointers and occupancy; clear drops everything but keeps tail so head==tail
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= tail_ptr;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry storage; contents need no reset because empty masks the head
  always_ff @(posedge CLK) begin
    if (push) mem[tail_ptr] <= push_dat;
  end

  assign head_dat = mem[head_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Purpose: match decode-time branch predictions against mem-stage outcomes, flush and redirect on mispredict (BRU_STATS_EN adds counters).
// Latency: verdict combinational in the resolve cycle; flush/redirect_pc one cycle later.
// Backpressure: full stalls decode; stall freezes queue push and pop; pushes dropped while recovering.
module branch_resolve_unit
  import datapath_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  branch_resolve_unit_if.slave  bus
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);

  bru_state_t  state_q;
  bru_state_t  state_d;
  bru_entry_t  head;
  bru_entry_t  push_rec;
  logic        q_full;
  logic        q_empty;
  logic        do_pop;
  logic        do_push;
  logic        mispredict_now;
  logic        dir_wrong;
  logic        tgt_wrong;
  logic [31:0] redirect_q;
  logic        err_q;

  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .push     (do_push),
    .pop      (do_pop),
    .clear    (mispredict_now),
    .push_dat (push_rec),
    .head_dat (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign push_rec = '{pc: bus.dec_pc, taken: bus.dec_taken, target: bus.dec_target};

  // A resolving branch retires only when the pipeline moves and there is something to retire.
  assign do_pop    = bus.mem_valid & ~bus.stall & ~q_empty;
  assign dir_wrong = (head.taken != bus.mem_taken);
  assign tgt_wrong = bus.mem_taken & (head.target != bus.mem_target);
  assign mispredict_now = do_pop & (dir_wrong | tgt_wrong);

  // A retiring head frees its slot on the same edge, so a full queue still accepts a push
  // alongside a pop. Nothing is recorded while recovering or when this cycle mispredicts,
  // since that decode-stage branch is on the wrong path.
  assign do_push = bus.dec_valid & ~bus.stall & (~q_full | do_pop)
                 & (state_q == NORMAL) & ~mispredict_now;

  // verdict for the predictor update
  always_comb begin
    bus.pred_result = NO_PRED;
    if (do_pop) begin
      bus.pred_result = mispredict_now ? WRONG_PRED : RIGHT_PRED;
    end
  end

  assign bus.pc_mem = q_empty ? 32'd0 : head.pc;
  assign bus.full   = q_full;

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= NORMAL;
    else       state_q <= state_d;
  end

  // next state: one recovery cycle per mispredict
  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (mispredict_now) state_d = RECOVER;
      RECOVER: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  assign bus.flush = (state_q == RECOVER);

  // correct fetch address, captured on the mispredicting pop and held afterwards
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      redirect_q <= '0;
    end else if (mispredict_now) begin
      redirect_q <= bus.mem_taken ? bus.mem_target : bru_fallthrough(head.pc);
    end
  end

  assign bus.redirect_pc = redirect_q;

  // sticky protocol error: mem stage resolved a branch we never saw predicted
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          err_q <= 1'b0;
    else if (bus.mem_valid && q_empty)  err_q <= 1'b1;
  end

  assign bus.err = err_q;

`ifdef BRU_STATS_EN
  // retired-branch and mispredict counters, free-running modulo 2^32
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (do_pop)         stat_branches    <= stat_branches + 32'd1;
      if (mispredict_now) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Purpose: directed and random stimulus for branch_resolve_unit against a queue-based reference.
// Latency: outputs sampled 1 time unit after each falling edge, before the next rising edge.
// Backpressure: exercised through full, stall and recovery windows.
module tb_branch_resolve_unit;
  import datapath_types_pkg::*;

  localparam int DEPTH = 4;

  logic CLK  = 1'b0;
  logic nRST = 1'b1;

  always #5 CLK = ~CLK;

  branch_resolve_unit_if bif();

`ifdef BRU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bif)
`ifdef BRU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // reference model state
  bru_entry_t  mq[$];
  logic        m_recover;
  logic [31:0] m_redirect;
  logic        m_err;
  logic [31:0] m_branches;
  logic [31:0] m_mis;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_recover  = 1'b0;
    m_redirect = 32'd0;
    m_err      = 1'b0;
    m_branches = 32'd0;
    m_mis      = 32'd0;
  endtask

  function automatic logic model_pop();
    return bif.mem_valid && !bif.stall && (mq.size() != 0);
  endfunction

  function automatic logic model_mis();
    if (!model_pop()) return 1'b0;
    return (mq[0].taken != bif.mem_taken) ||
           (bif.mem_taken && (mq[0].target != bif.mem_target));
  endfunction

  task automatic check_all(input string tag);
    pred_t ep;
    ep = !model_pop() ? NO_PRED : (model_mis() ? WRONG_PRED : RIGHT_PRED);
    chk({tag, "_pred"},  32'(bif.pred_result), 32'(ep));
    chk({tag, "_pcmem"}, bif.pc_mem, (mq.size() != 0) ? mq[0].pc : 32'd0);
    chk({tag, "_full"},  32'(bif.full), 32'(mq.size() == DEPTH));
    chk({tag, "_flush"}, 32'(bif.flush), 32'(m_recover));
    chk({tag, "_redir"}, bif.redirect_pc, m_redirect);
    chk({tag, "_err"},   32'(bif.err), 32'(m_err));
`ifdef BRU_STATS_EN
    chk({tag, "_stb"},   stat_branches, m_branches);
    chk({tag, "_stm"},   stat_mispredicts, m_mis);
`endif
  endtask

  // advance the model by one rising edge using the inputs presented this cycle
  task automatic model_update();
    logic       pop, mis, room, push_ok, was_empty;
    bru_entry_t h;
    pop       = model_pop();
    mis       = model_mis();
    was_empty = (mq.size() == 0);
    room      = (mq.size() < DEPTH) || pop;
    push_ok   = bif.dec_valid && !bif.stall && room && !m_recover && !mis;
    h         = '0;
    if (bif.mem_valid && was_empty) m_err = 1'b1;
    if (pop) begin
      h = mq.pop_front();
      m_branches = m_branches + 32'd1;
    end
    if (mis) begin
      m_mis      = m_mis + 32'd1;
      m_redirect = bif.mem_taken ? bif.mem_target : h.pc + 32'd4;
      mq.delete();
    end else if (push_ok) begin
      mq.push_back('{pc: bif.dec_pc, taken: bif.dec_taken, target: bif.dec_target});
    end
    m_recover = mis;
  endtask

  task automatic drive(input logic dv, input logic [31:0] dpc, input logic dtk,
                       input logic [31:0] dtgt, input logic mv, input logic mt,
                       input logic [31:0] mtgt, input logic st);
    bif.dec_valid  = dv;
    bif.dec_pc     = dpc;
    bif.dec_taken  = dtk;
    bif.dec_target = dtgt;
    bif.mem_valid  = mv;
    bif.mem_taken  = mt;
    bif.mem_target = mtgt;
    bif.stall      = st;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // check combinational/registered outputs, then take one clock edge
  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  logic [31:0] order [4];
  logic        r_dv, r_dtk, r_mv, r_mt, r_st;
  logic [31:0] r_dpc, r_dtgt, r_mtgt;

  initial begin
    idle();
    model_reset();
    #1 nRST = 1'b0;
    #2;
    check_all("reset");
    chk("reset_pred_const", 32'(bif.pred_result), 32'(NO_PRED));
    @(negedge CLK);
    nRST = 1'b1;

    // correct taken prediction
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle("s1_push");
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h200, 1'b0);
    #1;
    chk("s1_right", 32'(bif.pred_result), 32'(RIGHT_PRED));
    chk("s1_pcmem", bif.pc_mem, 32'h100);
    cycle("s1_pop");
    idle();
    #1 chk("s1_noflush", 32'(bif.flush), 32'd0);
    cycle("s1_after");

    // not-taken predicted, actually taken
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle("s2_push");
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h180, 1'b0);
    #1 chk("s2_wrong", 32'(bif.pred_result), 32'(WRONG_PRED));
    cycle("s2_pop");
    idle();
    #1;
    chk("s2_flush", 32'(bif.flush), 32'd1);
    chk("s2_redir", bif.redirect_pc, 32'h180);
    chk("s2_empty", bif.pc_mem, 32'd0);
    cycle("s2_recover");
    #1 chk("s2_flush_end", 32'(bif.flush), 32'd0);
    cycle("s2_after");

    // taken predicted, actually not taken; concurrent push dropped
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle("s3_push");
    drive(1'b1, 32'h300, 1'b1, 32'h340, 1'b1, 1'b0, 32'd0, 1'b0);
    #1 chk("s3_wrong", 32'(bif.pred_result), 32'(WRONG_PRED));
    cycle("s3_pop");
    drive(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    chk("s3_redir", bif.redirect_pc, 32'h104);
    chk("s3_flush", 32'(bif.flush), 32'd1);
    cycle("s3_recover_push");
    idle();
    #1;
    chk("s3_cnt0_pc", bif.pc_mem, 32'd0);
    chk("s3_cnt0_full", 32'(bif.full), 32'd0);
    cycle("s3_after");

    // fill, overflow drop, pop+push at full across the pointer wrap
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i * 16), 1'b1, 32'(i * 16) + 32'h1000, 1'b0, 1'b0, 32'd0, 1'b0);
      cycle("s4_fill");
    end
    drive(1'b1, 32'h50, 1'b1, 32'h1050, 1'b0, 1'b0, 32'd0, 1'b0);
    #1 chk("s4_full", 32'(bif.full), 32'd1);
    cycle("s4_overflow");
    drive(1'b1, 32'h60, 1'b1, 32'h1060, 1'b1, 1'b1, 32'h1010, 1'b0);
    #1 chk("s4_head0", bif.pc_mem, 32'h10);
    cycle("s4_poppush");
    order[0] = 32'h20; order[1] = 32'h30; order[2] = 32'h40; order[3] = 32'h60;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, order[i] + 32'h1000, 1'b0);
      #1;
      if (i == 0) chk("s4_full_kept", 32'(bif.full), 32'd1);
      chk("s4_order", bif.pc_mem, order[i]);
      cycle("s4_drain");
    end

    // resolve with empty queue, then stalled resolve
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h200, 1'b0);
    #1 chk("s5_nopred", 32'(bif.pred_result), 32'(NO_PRED));
    cycle("s5_empty_resolve");
    drive(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 32'd0, 1'b0);
    #1 chk("s5_err", 32'(bif.err), 32'd1);
    cycle("s5_push");
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h600, 1'b1);
    #1 chk("s5_stall_nopred", 32'(bif.pred_result), 32'(NO_PRED));
    cycle("s5_stall");
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h600, 1'b0);
    #1;
    chk("s5_still_head", bif.pc_mem, 32'h500);
    chk("s5_err_sticky", 32'(bif.err), 32'd1);
    cycle("s5_pop");

    // reset while flushing
    drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle("s6_push");
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h800, 1'b0);
    cycle("s6_mis");
    idle();
    #1 chk("s6_flush_on", 32'(bif.flush), 32'd1);
    nRST = 1'b0;
    #1;
    model_reset();
    chk("s6_rst_flush", 32'(bif.flush), 32'd0);
    chk("s6_rst_redir", bif.redirect_pc, 32'd0);
    chk("s6_rst_err", 32'(bif.err), 32'd0);
    check_all("s6_rst");
    @(negedge CLK);
    nRST = 1'b1;
    cycle("s6_post");

    // three pops, one mispredict
    drive(1'b1, 32'h10, 1'b1, 32'h1010, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle("s7_push");
    drive(1'b1, 32'h20, 1'b1, 32'h1020, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle("s7_push");
    drive(1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle("s7_push");
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1010, 1'b0);
    cycle("s7_pop");
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1020, 1'b0);
    cycle("s7_pop");
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h2000, 1'b0);
    cycle("s7_pop");
    idle();
    #1 chk("s7_redir", bif.redirect_pc, 32'h2000);
`ifdef BRU_STATS_EN
    chk("s7_stat_br", stat_branches, 32'd3);
    chk("s7_stat_mis", stat_mispredicts, 32'd1);
`endif
    cycle("s7_after");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r_dv   = ($urandom_range(0, 9) < 6);
      r_dpc  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) r_dpc = 32'hFFFF_FFFC;
      r_dtk  = $urandom_range(0, 1);
      r_dtgt = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h10;
      r_mv   = ($urandom_range(0, 9) < 5);
      r_mt   = $urandom_range(0, 1);
      r_mtgt = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h10;
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
        r_mt   = mq[0].taken;
        r_mtgt = mq[0].target;
      end
      r_st   = ($urandom_range(0, 9) == 0);
      drive(r_dv, r_dpc, r_dtk, r_dtgt, r_mv, r_mt, r_mtgt, r_st);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight prediction queue entries (power of 2, >=2).
REQ-002 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port nRST  input  1  asynchronous active-low reset.
REQ-004 SHALL have port dec_valid  input  1  decode-stage branch carries a prediction this cycle.
REQ-005 SHALL have port dec_pc  input  32  decode-stage branch PC.
REQ-006 SHALL have port dec_taken  input  1  predicted direction (predictor pred_control).
REQ-007 SHALL have port dec_target  input  32  predicted taken target.
REQ-008 SHALL have port stall  input  1  pipeline frozen; no push, no pop.
REQ-009 SHALL have port mem_valid  input  1  branch resolving in mem stage.
REQ-010 SHALL have port mem_taken  input  1  actual direction.
REQ-011 SHALL have port mem_target  input  32  actual taken target.
REQ-012 SHALL have port pred_result  output  2  pred_t verdict for predictor update.
REQ-013 SHALL have port pc_mem  output  32  PC of resolving branch, for predictor indexing.
REQ-014 SHALL have port flush  output  1  squash younger instructions.
REQ-015 SHALL have port redirect_pc  output  32  correct fetch PC, valid while flush=1.
REQ-016 SHALL have port full  output  1  queue full; decode must stall.
REQ-017 SHALL have port err  output  1  sticky: mem_valid seen with empty queue.

Function
REQ-018 Push: dec_valid & !stall & !full & state==NORMAL & !mispredict_now writes {dec_pc,dec_taken,dec_target} at tail; otherwise record is dropped.
REQ-019 Pop: mem_valid & !stall & !empty retires head; pop and push in same cycle both take effect, count unchanged.
REQ-020 mispredict_now = pop & (head.taken != mem_taken | (mem_taken & head.target != mem_target)).
REQ-021 pred_result SHALL be combinational: NO_PRED unless pop; WRONG_PRED if mispredict_now; else RIGHT_PRED.
REQ-022 pc_mem SHALL equal head.pc combinationally (0 when empty).
REQ-023 FSM states NORMAL, RECOVER; NORMAL->RECOVER on mispredict_now; RECOVER->NORMAL unconditionally next cycle.
REQ-024 flush=1 exactly the cycle in RECOVER (one cycle after mispredict), independent of stall.
REQ-025 redirect_pc registered on mispredict: mem_target if mem_taken, else head.pc+4 (mod 2^32); holds value otherwise.
REQ-026 Entering RECOVER SHALL clear the queue (head=tail, count=0) in the same edge as the pop; pushes in RECOVER are dropped.
REQ-027 full = (count==DEPTH); count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-028 mem_valid with empty queue: no pop, pred_result=NO_PRED, err set until reset.

Reset
REQ-029 nRST low SHALL asynchronously set state=NORMAL, pointers/count=0, flush=0, redirect_pc=0, err=0, counters=0; full=0, pred_result=NO_PRED, pc_mem=0 follow.
REQ-030 Reset mid-recovery SHALL abort RECOVER with flush=0 on next cycle.

Configuration
REQ-031 With BRU_STATS_EN defined: outputs stat_branches (32) and stat_mispredicts (32) SHALL count pops and mispredicts, wrapping at 2^32; without it these ports and registers SHALL not exist.

Structure
REQ-032 pred_t {NO_PRED, RIGHT_PRED, WRONG_PRED} and bru_state_t SHALL live in datapath_types_pkg; queue entry struct bru_entry_t likewise.
REQ-033 Queue SHALL be sub-module bru_fifo (DEPTH param, push/pop/clear, full/empty, head data).

Verification
REQ-034 Push pc=0x100 taken tgt=0x200; pop mem_taken=1 tgt=0x200 -> pred_result=RIGHT_PRED, pc_mem=0x100, flush stays 0.
REQ-035 Push pc=0x100 not-taken; pop mem_taken=1 tgt=0x180 -> WRONG_PRED same cycle, next cycle flush=1, redirect_pc=0x180, queue empty.
REQ-036 Push pc=0x100 taken tgt=0x200; pop mem_taken=0 -> redirect_pc=0x104; simultaneous push in that cycle dropped, count=0.
REQ-037 Push 4 entries -> full=1, 5th push dropped; pop+push same cycle -> full stays 1, order preserved across pointer wrap.
REQ-038 mem_valid on empty queue -> NO_PRED, err=1 sticky; stall=1 with mem_valid -> no pop, NO_PRED.
REQ-039 nRST low during flush=1 -> all outputs at reset values immediately; with BRU_STATS_EN, 3 pops/1 mispredict -> counters 3/1.
